// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32M divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: div_op_t (op encoding), div_state_t (FSM states),
//           default widths, and the RISC-V special-case result constants.
package riscv_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_REG_AW = 5;

  // Quotient returned for any divide by zero.
  localparam logic [DEF_XLEN-1:0] DIV_ONES = '1;
  // Most negative signed value; also the quotient of INT_MIN / -1.
  localparam logic [DEF_XLEN-1:0] INT_MIN  = {1'b1, {(DEF_XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIN  = 2'b10
  } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// Pipeline-controller <-> divider bundle: request operands in, writeback out.
// Latency: n/a (wires only).
// Backpressure: none; the controller must watch busy and treats start while busy as dropped.
// master: drives start/flush/op/dividend/divisor/rd, sees busy/done/result/write_reg/reg_write.
// slave : the divider, opposite directions.
interface div_unit_if #(
  parameter int XLEN   = riscv_pkg::DEF_XLEN,
  parameter int REG_AW = riscv_pkg::DEF_REG_AW
) ();
  import riscv_pkg::*;

  logic              start;
  logic              flush;
  div_op_t           op;
  logic [XLEN-1:0]   dividend;
  logic [XLEN-1:0]   divisor;
  logic [REG_AW-1:0] rd;

  logic              busy;
  logic              done;
  logic [XLEN-1:0]   result;
  logic [REG_AW-1:0] write_reg;
  logic              reg_write;

  modport master (
    output start, flush, op, dividend, divisor, rd,
    input  busy, done, result, write_reg, reg_write
  );

  modport slave (
    input  start, flush, op, dividend, divisor, rd,
    output busy, done, result, write_reg, reg_write
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract, restore on borrow.
// Latency: combinational.
// Backpressure: none.
// Ports: rem_in/quo_in partial remainder and quotient, dvsr divisor; rem_out/quo_out next values.
module div_step #(
  parameter int XLEN = riscv_pkg::DEF_XLEN
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] dvsr,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    // One extra bit holds the bit shifted out of rem; since rem < dvsr,
    // shifted < 2*dvsr and the borrow shows up as diff[XLEN].
    shifted = {rem_in, quo_in[XLEN-1]};
    diff    = shifted - {1'b0, dvsr};
    if (!diff[XLEN]) begin
      rem_out = diff[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end else begin
      rem_out = shifted[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU, radix-2 restoring, one quotient bit per clock.
// Latency: XLEN+1 cycles from the sampling edge to done; 1 cycle for divide-by-zero and signed overflow.
// Backpressure: start is only honoured in IDLE; start while busy is dropped. flush aborts silently.
// Ports: CLK, RST_N (async active-low); bus = div_unit_if.slave carrying the request and
//        the register-file writeback (result/write_reg/reg_write, done pulse, busy).
module div_unit #(
  parameter int XLEN   = riscv_pkg::DEF_XLEN,
  parameter int REG_AW = riscv_pkg::DEF_REG_AW
) (
  input  logic       CLK,
  input  logic       RST_N,
  div_unit_if.slave  bus
);
  import riscv_pkg::*;

  localparam int              CW   = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t        state, state_nxt;
  logic [XLEN-1:0]   rem_q, quo_q, dvsr_q;
  logic [CW-1:0]     cnt_q;
  logic              is_rem_q, q_neg_q, r_neg_q;
  logic [REG_AW-1:0] rd_q;
  logic [XLEN-1:0]   result_q;
  logic [REG_AW-1:0] wreg_q;

  logic [XLEN-1:0]   rem_nxt, quo_nxt;
  logic              in_signed, in_rem, a_neg, b_neg, div0, ovf, accept, fin_ok;
  logic [XLEN-1:0]   abs_a, abs_b, fin_val;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .dvsr    (dvsr_q),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  // Request decode, only meaningful in IDLE.
  assign in_signed = (bus.op == DIV) || (bus.op == REM);
  assign in_rem    = (bus.op == REM) || (bus.op == REMU);
  assign a_neg     = in_signed && bus.dividend[XLEN-1];
  assign b_neg     = in_signed && bus.divisor[XLEN-1];
  assign abs_a     = a_neg ? -bus.dividend : bus.dividend;
  assign abs_b     = b_neg ? -bus.divisor  : bus.divisor;
  assign div0      = (bus.divisor == '0);
  assign ovf       = in_signed && (bus.dividend == MINV) && (bus.divisor == ONES);
  assign accept    = (state == IDLE) && bus.start && !bus.flush;

  // Sign correction applied on the way out; special cases park their
  // final values in quo_q/rem_q with both sign flags cleared.
  assign fin_val = is_rem_q ? (r_neg_q ? -rem_q : rem_q)
                            : (q_neg_q ? -quo_q : quo_q);

  // A flush in FIN suppresses the pulse and leaves the held result alone.
  assign fin_ok = (state == FIN) && !bus.flush;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (div0 || ovf) ? FIN : CALC;
      CALC: begin
        if (bus.flush)          state_nxt = IDLE;
        else if (cnt_q == LAST) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      is_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
      wreg_q   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            is_rem_q <= in_rem;
            rd_q     <= bus.rd;
            cnt_q    <= '0;
            dvsr_q   <= abs_b;
            if (div0) begin
              quo_q   <= ONES;
              rem_q   <= bus.dividend;
              q_neg_q <= 1'b0;
              r_neg_q <= 1'b0;
            end else if (ovf) begin
              quo_q   <= MINV;
              rem_q   <= '0;
              q_neg_q <= 1'b0;
              r_neg_q <= 1'b0;
            end else begin
              quo_q   <= abs_a;
              rem_q   <= '0;
              q_neg_q <= a_neg ^ b_neg;
              r_neg_q <= a_neg;
            end
          end
        end
        CALC: begin
          if (!bus.flush) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FIN: begin
          if (fin_ok) begin
            result_q <= fin_val;
            wreg_q   <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = fin_ok;
  assign bus.result    = fin_ok ? fin_val : result_q;
  assign bus.write_reg = fin_ok ? rd_q : wreg_q;
  assign bus.reg_write = fin_ok && (rd_q != '0);

endmodule
